// File: rtl/mw_eeprom_sequencer.sv
// Microwire sequencer for one 93C46-class EEPROM (x16): frames READ/WRITE/ERASE/EWEN/EWDS
// from a req/ack command port and polls ready/busy after programming commands.
module mw_eeprom_sequencer #(
    parameter int CLK_DIV     = 4,
    parameter int TIMEOUT_CYC = 20000,
    parameter int CS_GAP      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  cmd,
    input  logic [5:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic        cs,
    output logic        sk,
    output logic        di,
    input  logic        do_in
);
    localparam int GAP_CYC = CS_GAP * 2 * CLK_DIV;
    localparam int TMR_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] CMD_READ  = 3'b000;
    localparam logic [2:0] CMD_WRITE = 3'b001;
    localparam logic [2:0] CMD_ERASE = 3'b010;
    localparam logic [2:0] CMD_EWEN  = 3'b011;
    localparam logic [2:0] CMD_EWDS  = 3'b100;

    typedef enum logic [2:0] {IDLE, DECODE, SETUP, SHIFT, DATA, DESEL, POLL, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]       cmd_q;
    logic [5:0]       addr_q;
    logic [15:0]      wdata_q;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [TMR_W-1:0] tmr;
    logic [24:0]      shreg;
    logic [15:0]      rd_sh;
    logic             do_s1, do_s2;

    logic        tick, legal, is_read, is_write, polls;
    logic [4:0]  n_total, n_drive;
    logic [8:0]  header;
    logic [24:0] frame;

    always_comb begin
        state_nxt = state;
        tick      = (div_cnt == DIV_LAST);
        legal     = (cmd_q <= CMD_EWDS);
        is_read   = (cmd_q == CMD_READ);
        is_write  = (cmd_q == CMD_WRITE);
        polls     = is_write || (cmd_q == CMD_ERASE);
        n_total   = (is_read || is_write) ? 5'd25 : 5'd9;
        n_drive   = is_write ? 5'd25 : 5'd9;
        busy      = (state != IDLE) || ack;
        case (cmd_q)
            CMD_READ:  header = {3'b110, addr_q};
            CMD_WRITE: header = {3'b101, addr_q};
            CMD_ERASE: header = {3'b111, addr_q};
            CMD_EWEN:  header = {3'b100, 6'b110000};
            default:   header = {3'b100, 6'b000000};
        endcase
        frame = {header, wdata_q};

        case (state)
            IDLE:   if (req && !ack) state_nxt = DECODE;
            DECODE: state_nxt = legal ? SETUP : IDLE;
            SETUP:  if (tick) state_nxt = SHIFT;
            SHIFT, DATA: begin
                if (tick && !sk) begin
                    if (bit_cnt == n_total)
                        state_nxt = DESEL;
                    else if (bit_cnt == 5'd9 && n_total == 5'd25)
                        state_nxt = DATA;
                end
            end
            DESEL:  if (tmr == GAP_LAST) state_nxt = polls ? POLL : DONE;
            POLL:   if (do_s2 || tmr == TMO_LAST) state_nxt = IDLE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs      <= 1'b0;
            sk      <= 1'b0;
            di      <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tmr     <= '0;
            shreg   <= '0;
            rd_sh   <= '0;
            do_s1   <= 1'b0;
            do_s2   <= 1'b0;
        end else begin
            ack   <= 1'b0;
            do_s1 <= do_in;
            do_s2 <= do_s1;
            case (state)
                IDLE: begin
                    if (req && !ack) begin
                        cmd_q   <= cmd;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        err     <= 1'b0;
                    end
                end
                DECODE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sk      <= 1'b0;
                    if (legal) begin
                        cs    <= 1'b1;
                        di    <= frame[24];
                        shreg <= frame;
                    end else begin
                        ack <= 1'b1;
                        err <= 1'b1;
                    end
                end
                SETUP: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) sk <= 1'b1;
                end
                SHIFT, DATA: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        if (sk) begin
                            // Falling edge: advance to the next bit, or park di low once out of bits.
                            sk      <= 1'b0;
                            bit_cnt <= bit_cnt + 5'd1;
                            shreg   <= {shreg[23:0], 1'b0};
                            di      <= (bit_cnt + 5'd1 < n_drive) ? shreg[23] : 1'b0;
                        end else if (bit_cnt == n_total) begin
                            cs  <= 1'b0;
                            di  <= 1'b0;
                            tmr <= '0;
                        end else begin
                            // Rising edge: sample 9 is the dummy 0, samples 10..25 are D15..D0.
                            sk <= 1'b1;
                            if (is_read && bit_cnt >= 5'd9) rd_sh <= {rd_sh[14:0], do_in};
                        end
                    end
                end
                DESEL: begin
                    tmr <= (tmr == GAP_LAST) ? '0 : tmr + 1'b1;
                    if (tmr == GAP_LAST && polls) cs <= 1'b1;
                end
                POLL: begin
                    tmr <= tmr + 1'b1;
                    if (do_s2 || tmr == TMO_LAST) begin
                        cs  <= 1'b0;
                        ack <= 1'b1;
                        err <= !do_s2;
                    end
                end
                DONE: begin
                    ack <= 1'b1;
                    if (is_read) rdata <= rd_sh;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mw_eeprom_sequencer.sv
// Directed bench for mw_eeprom_sequencer with a small Microwire EEPROM model and frame monitor.
module tb_mw_eeprom_sequencer;
    localparam int CLK_DIV = 4;
    localparam int TMO     = 400;
    localparam int GAP     = 2;

    logic        clk = 1'b0;
    logic        rst_n, req;
    logic [2:0]  cmd;
    logic [5:0]  addr;
    logic [15:0] wdata, rdata;
    logic        ack, err, busy, cs, sk, di, do_in;

    logic        poll_mode = 1'b0, ready = 1'b0, rd_bit = 1'b0;
    logic [15:0] rd_word = 16'h0;
    int          cyc = 0, checks = 0, errors = 0;
    int          ack_cnt = 0, cs_rises = 0, sp_bad = 0, idle_bad = 0;
    int          rise_n = 0, last_n = 0, last_t = 0;
    logic [24:0] bits = '0, last_frame = '0;
    logic        sk_q = 1'b0, cs_q = 1'b0;

    assign do_in = poll_mode ? ready : rd_bit;

    mw_eeprom_sequencer #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYC(TMO), .CS_GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy), .cs(cs), .sk(sk), .di(di),
        .do_in(do_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // EEPROM model and pin monitor: records di on sk rises, serves read data, tracks edge spacing.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ack) ack_cnt++;
            if (!cs && (sk || di)) idle_bad++;
            if (cs && !cs_q) begin cs_rises++; last_t = cyc; end
            if (cs) begin
                if (sk !== sk_q) begin
                    if (cyc - last_t != CLK_DIV) sp_bad++;
                    last_t = cyc;
                    if (sk) begin
                        bits = {bits[23:0], di};
                        rise_n++;
                        rd_bit = (rise_n >= 9 && rise_n <= 24) ? rd_word[24 - rise_n] : 1'b0;
                    end
                end
            end else begin
                if (rise_n > 0) begin last_frame = bits; last_n = rise_n; end
                rise_n = 0;
                bits   = '0;
                rd_bit = 1'b0;
            end
            sk_q = sk;
            cs_q = cs;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic [5:0] a, input logic [15:0] d);
        req = 1'b1; cmd = c; addr = a; wdata = d;
        step();
        req = 1'b0;
        chk("accept_busy", {31'b0, busy}, 1);
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (ack === 1'b1) begin n = i; break; end
        end
    endtask

    task automatic wait_cs(input logic lvl, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (cs === lvl) begin n = i; break; end
        end
    endtask

    initial begin
        int n, f, base;
        rst_n = 1'b0; req = 1'b0; cmd = 3'b0; addr = 6'h0; wdata = 16'h0;
        repeat (3) step();
        chk("rst_pins", {26'b0, cs, sk, di, ack, err, busy}, 0);
        chk("rst_rdata", {16'b0, rdata}, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Reset during WRITE data bit 5
        issue(3'b001, 6'h05, 16'hFFFF);
        n = -1;
        for (int i = 0; i < 400; i++) begin
            if (rise_n >= 15) begin n = i; break; end
            step();
        end
        chk("rst_reach_bit5", {31'b0, (n >= 0)}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cs", {31'b0, cs}, 0);
        chk("rst_mid_busy", {31'b0, busy}, 0);
        chk("rst_mid_sk", {31'b0, sk}, 0);
        step(); step();
        rst_n = 1'b1;
        base = ack_cnt;
        repeat (60) step();
        chk("rst_no_ack", ack_cnt - base, 0);

        // EWEN
        issue(3'b011, 6'h00, 16'h0);
        wait_ack(200, n);
        chk("ewen_lat", n, 94);
        chk("ewen_frame", {7'b0, last_frame}, {23'b0, 9'b1_00_110000});
        chk("ewen_nbits", last_n, 9);
        chk("ewen_err", {31'b0, err}, 0);
        step();

        // READ 0x2A -> 0xBEEF
        rd_word = 16'hBEEF;
        issue(3'b000, 6'h2A, 16'h0);
        wait_ack(400, n);
        chk("read_lat", n, 222);
        chk("read_rdata", {16'b0, rdata}, 32'h0000BEEF);
        chk("read_err", {31'b0, err}, 0);
        chk("read_frame", {7'b0, last_frame}, {7'b0, 9'b1_10_101010, 16'h0});
        chk("read_nbits", last_n, 25);
        step();
        chk("ack_width", {31'b0, ack}, 0);

        // WRITE 0x05 <- 0x1234 with 300 clk busy
        issue(3'b001, 6'h05, 16'h1234);
        wait_cs(1'b1, 20, n);
        wait_cs(1'b0, 400, n);
        f = cyc;
        chk("write_frame", {7'b0, last_frame}, {7'b0, 9'b1_01_000101, 16'h1234});
        chk("write_nbits", last_n, 25);
        wait_cs(1'b1, 100, n);
        chk("write_cs_gap", cyc - f, 16);
        poll_mode = 1'b1; ready = 1'b0;
        base = ack_cnt;
        repeat (300) step();
        chk("write_busy_noack", ack_cnt - base, 0);
        chk("write_poll_cs", {31'b0, cs}, 1);
        ready = 1'b1;
        wait_ack(10, n);
        chk("write_ready_ack", n, 3);
        chk("write_err", {31'b0, err}, 0);
        chk("write_cs_after", {31'b0, cs}, 0);
        ready = 1'b0; poll_mode = 1'b0;
        step();

        // ERASE 0x11, never ready -> timeout
        poll_mode = 1'b1;
        issue(3'b010, 6'h11, 16'h0);
        wait_cs(1'b1, 20, n);
        wait_cs(1'b0, 200, n);
        chk("erase_frame", {7'b0, last_frame}, {23'b0, 9'b1_11_010001});
        wait_cs(1'b1, 100, n);
        wait_ack(600, n);
        chk("erase_tmo_lat", n, TMO);
        chk("erase_err", {31'b0, err}, 1);
        chk("erase_cs_after", {31'b0, cs}, 0);
        poll_mode = 1'b0;
        step();

        // Illegal command, then EWDS clears err
        base = cs_rises;
        issue(3'b111, 6'h3F, 16'h0);
        wait_ack(10, n);
        chk("illegal_lat", n, 1);
        chk("illegal_err", {31'b0, err}, 1);
        repeat (4) step();
        chk("illegal_no_cs", cs_rises - base, 0);
        issue(3'b100, 6'h00, 16'h0);
        chk("err_cleared", {31'b0, err}, 0);
        wait_ack(200, n);
        chk("ewds_lat", n, 94);
        chk("ewds_frame", {7'b0, last_frame}, {23'b0, 9'b1_00_000000});
        step();

        // req held across two READs with input glitches while busy
        base = ack_cnt;
        rd_word = 16'h5A5A;
        req = 1'b1; cmd = 3'b000; addr = 6'h15;
        step();
        chk("hold_accept", {31'b0, busy}, 1);
        for (int i = 0; i < 20; i++) begin
            cmd = 3'($urandom_range(0, 7));
            addr = 6'($urandom_range(0, 63));
            step();
        end
        cmd = 3'b000; addr = 6'h33;
        wait_ack(400, n);
        chk("hold_lat1", n + 20, 222);
        chk("hold_rdata1", {16'b0, rdata}, 32'h00005A5A);
        chk("hold_frame1", {7'b0, last_frame}, {7'b0, 9'b1_10_010101, 16'h0});
        rd_word = 16'hC3A1;
        wait_cs(1'b1, 20, n);
        req = 1'b0;
        wait_ack(400, n);
        chk("hold_rdata2", {16'b0, rdata}, 32'h0000C3A1);
        chk("hold_frame2", {7'b0, last_frame}, {7'b0, 9'b1_10_110011, 16'h0});
        chk("hold_err", {31'b0, err}, 0);
        repeat (30) step();
        chk("hold_ack_count", ack_cnt - base, 2);

        chk("sk_spacing", sp_bad, 0);
        chk("idle_pins", idle_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
